// File: rtl/shifter_reg_n.sv
// -----------------------------------------------------------------------------
// shifter_reg_n
//
// A WIDTH-bit shift register. It updates once per clock from a 3-bit op:
// load, logical and arithmetic shifts, rotates, and serial shift-in.
// Besides the register it keeps two things:
//   carry - the last bit shifted or rotated out.
//   zero  - a flag that reads 1 when the register is zero.
// A shift amount of WIDTH or more has a defined result: the register fills
// with zeros, or with copies of the sign bit for ASR.
//
// Optional feature macro: SHIFTER_ROTATE_EN
//   defined   : ROL (101) and ROR (110) rotate by shamt mod WIDTH.
//   undefined : 101 and 110 act as NOP, and no rotate logic is built.
//
// Parameters:
//   WIDTH   - register and data width, 2..64.
//   SHAMT_W - width of shamt, 1..7. shamt may exceed WIDTH-1.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset; clears d_out and carry
//   en     in   update enable; when 0, d_out and carry hold
//   op     in   operation select (see op_e below)
//   shamt  in   shift/rotate amount k
//   s_in   in   serial input bit for SHIN
//   d_in   in   parallel load data
//   d_out  out  registered register contents
//   carry  out  registered last bit shifted or rotated out
//   zero   out  combinational, 1 when d_out == 0
// -----------------------------------------------------------------------------
module shifter_reg_n #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               s_in,
  input  logic [WIDTH-1:0]   d_in,
  output logic [WIDTH-1:0]   d_out,
  output logic               carry,
  output logic               zero
);

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_LSL  = 3'b010,
    OP_LSR  = 3'b011,
    OP_ASR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ROR  = 3'b110,
    OP_SHIN = 3'b111
  } op_e;

  op_e op_sel;
  assign op_sel = op_e'(op);

  // Each shift works on a register that is one bit wider than the data.
  // The extra bit, placed on the side the data leaves from, catches the last
  // bit shifted out. This gives the right carry for every amount:
  //   - For 1 <= k <= WIDTH, carry is the last data bit that left.
  //   - For k > WIDTH, carry is the fill bit instead (zero, or the sign for
  //     ASR).
  // The SV shift operators already saturate for large amounts, so no
  // range checks are needed.
  logic [WIDTH:0] lsl_full;  // {carry, result}
  logic [WIDTH:0] lsr_full;  // {result, carry}
  logic [WIDTH:0] asr_full;  // {result, carry}

  always_comb begin
    lsl_full = {1'b0, d_out} << shamt;
    lsr_full = {d_out, 1'b0} >> shamt;
    asr_full = $signed({d_out, 1'b0}) >>> shamt;
  end

`ifdef SHIFTER_ROTATE_EN
  localparam logic [31:0] W_U = 32'(WIDTH);

  logic [31:0]      rot_amt;
  logic [WIDTH-1:0] rol_res;
  logic [WIDTH-1:0] ror_res;

  // When rot_amt is 0, the complementary shift is by WIDTH and yields 0.
  // The OR then gives d_out back unchanged; that case is also gated off
  // below so carry holds.
  always_comb begin
    rot_amt = 32'(shamt) % W_U;
    rol_res = (d_out << rot_amt) | (d_out >> (W_U - rot_amt));
    ror_res = (d_out >> rot_amt) | (d_out << (W_U - rot_amt));
  end
`endif

  logic [WIDTH-1:0] d_next;
  logic             carry_next;
  logic             k_zero;

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so
    // the paths that do not assign it cannot infer a latch.
    d_next     = d_out;
    carry_next = carry;
    k_zero     = (shamt == '0);

    case (op_sel)
      OP_LOAD: begin
        d_next     = d_in;
        carry_next = 1'b0;
      end
      OP_LSL: if (!k_zero) {carry_next, d_next} = lsl_full;
      OP_LSR: if (!k_zero) {d_next, carry_next} = lsr_full;
      OP_ASR: if (!k_zero) {d_next, carry_next} = asr_full;
`ifdef SHIFTER_ROTATE_EN
      OP_ROL: begin
        if (rot_amt != '0) begin
          d_next     = rol_res;
          carry_next = rol_res[0];
        end
      end
      OP_ROR: begin
        if (rot_amt != '0) begin
          d_next     = ror_res;
          carry_next = ror_res[WIDTH-1];
        end
      end
`endif
      OP_SHIN: begin
        d_next     = {d_out[WIDTH-2:0], s_in};
        carry_next = d_out[WIDTH-1];
      end
      default: ;  // NOP, and ROL/ROR when rotates are not built: hold
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments. All flops then
    // sample the values from before the edge, so simulation matches the
    // hardware.
    if (reset) begin
      d_out <= '0;
      carry <= 1'b0;
    end else if (en) begin
      d_out <= d_next;
      carry <= carry_next;
    end
  end

  assign zero = (d_out == '0);

endmodule

// File: tb/tb_shifter_reg_n.sv
// -----------------------------------------------------------------------------
// tb_shifter_reg_n
//
// Scoreboard bench for shifter_reg_n with two instances:
//   - WIDTH=8,  SHAMT_W=4 : wide enough shamt to reach k > WIDTH.
//   - WIDTH=16, SHAMT_W=4
//
// The stimulus process drives both instances on the falling edge. It pushes
// the reference model's expected state into one queue per instance. A
// separate monitor pops the queues just after each rising edge and compares
// them with the outputs.
//
// The model computes every op from its arithmetic definition on a 64-bit
// value masked to the width. The rotate ops follow SHIFTER_ROTATE_EN in the
// same way as the design.
// -----------------------------------------------------------------------------
module tb_shifter_reg_n;

  localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, LSL = 3'd2, LSR = 3'd3,
                         ASR = 3'd4, ROL = 3'd5, ROR = 3'd6, SHIN = 3'd7;

  typedef struct {
    logic        reset;
    logic        en;
    logic [2:0]  op;
    int unsigned k;
    logic        s;
    logic [63:0] d;
  } stim_t;

  typedef struct {
    logic [63:0] d;
    logic        c;
  } st_t;

  typedef struct {
    int          id;
    logic [63:0] d;
    logic        c;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic        reset8 = 1'b0, en8 = 1'b0, s_in8 = 1'b0;
  logic [2:0]  op8 = 3'd0;
  logic [3:0]  shamt8 = '0;
  logic [7:0]  d_in8 = '0, d_out8;
  logic        carry8, zero8;

  // 16-bit instance
  logic        reset16 = 1'b0, en16 = 1'b0, s_in16 = 1'b0;
  logic [2:0]  op16 = 3'd0;
  logic [3:0]  shamt16 = '0;
  logic [15:0] d_in16 = '0, d_out16;
  logic        carry16, zero16;

  shifter_reg_n #(.WIDTH(8), .SHAMT_W(4)) dut8 (
    .clk(clk), .reset(reset8), .en(en8), .op(op8), .shamt(shamt8),
    .s_in(s_in8), .d_in(d_in8), .d_out(d_out8), .carry(carry8), .zero(zero8)
  );

  shifter_reg_n #(.WIDTH(16), .SHAMT_W(4)) dut16 (
    .clk(clk), .reset(reset16), .en(en16), .op(op16), .shamt(shamt16),
    .s_in(s_in16), .d_in(d_in16), .d_out(d_out16), .carry(carry16), .zero(zero16)
  );

  exp_t  q8[$];
  exp_t  q16[$];
  st_t   m8  = '{d: 64'd0, c: 1'b0};
  st_t   m16 = '{d: 64'd0, c: 1'b0};
  stim_t s8, s16;
  int    step_id = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    done = 1'b0;

  // Reference model: next state of a w-bit register.
  function automatic st_t predict(input int w, input stim_t s, input st_t cur);
    st_t         nx;
    logic [63:0] mask;
    logic [63:0] dv;
    logic        sign;
    int          k;
    int          r;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    dv   = cur.d & mask;
    sign = dv[w-1];
    k    = int'(s.k);
    nx   = cur;
    if (s.reset) begin
      nx.d = '0;
      nx.c = 1'b0;
    end else if (s.en) begin
      case (s.op)
        LOAD: begin
          nx.d = s.d & mask;
          nx.c = 1'b0;
        end
        LSL: if (k != 0) begin
          nx.c = (k <= w) ? dv[w-k] : 1'b0;
          nx.d = (k >= w) ? 64'd0 : ((dv << k) & mask);
        end
        LSR: if (k != 0) begin
          nx.c = (k <= w) ? dv[k-1] : 1'b0;
          nx.d = (k >= w) ? 64'd0 : (dv >> k);
        end
        ASR: if (k != 0) begin
          nx.c = (k <= w) ? dv[k-1] : sign;
          if (k >= w) nx.d = sign ? mask : 64'd0;
          else        nx.d = (dv >> k) | (sign ? (mask & ~(mask >> k)) : 64'd0);
        end
`ifdef SHIFTER_ROTATE_EN
        ROL: begin
          r = k % w;
          if (r != 0) begin
            nx.d = ((dv << r) | (dv >> (w - r))) & mask;
            nx.c = nx.d[0];
          end
        end
        ROR: begin
          r = k % w;
          if (r != 0) begin
            nx.d = ((dv >> r) | (dv << (w - r))) & mask;
            nx.c = nx.d[w-1];
          end
        end
`endif
        SHIN: begin
          nx.d = ((dv << 1) | {63'd0, s.s}) & mask;
          nx.c = sign;
        end
        default: ;
      endcase
    end
    return nx;
  endfunction

  task automatic check(input string name, input int id,
                       input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s (step %0d): got %h, want %h", name, id, got, want);
    end
  endtask

  // Monitor: the outputs are valid every cycle once a step has been issued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q8.size() > 0) begin
        e = q8.pop_front();
        check("w8 d_out", e.id, 64'(d_out8),  e.d);
        check("w8 carry", e.id, 64'(carry8),  64'(e.c));
        check("w8 zero",  e.id, 64'(zero8),   64'(e.z));
      end
      if (q16.size() > 0) begin
        e = q16.pop_front();
        check("w16 d_out", e.id, 64'(d_out16), e.d);
        check("w16 carry", e.id, 64'(carry16), 64'(e.c));
        check("w16 zero",  e.id, 64'(zero16),  64'(e.z));
      end
    end
  end

  // Issue one cycle of stimulus to both instances and push the expectations.
  task automatic apply();
    st_t nx;
    @(negedge clk);
    reset8 = s8.reset;  en8 = s8.en;  op8 = s8.op;  shamt8 = 4'(s8.k);
    s_in8 = s8.s;       d_in8 = s8.d[7:0];
    reset16 = s16.reset; en16 = s16.en; op16 = s16.op; shamt16 = 4'(s16.k);
    s_in16 = s16.s;      d_in16 = s16.d[15:0];
    step_id++;
    nx = predict(8, s8, m8);
    q8.push_back('{id: step_id, d: nx.d, c: nx.c, z: (nx.d == 64'd0)});
    m8 = nx;
    nx = predict(16, s16, m16);
    q16.push_back('{id: step_id, d: nx.d, c: nx.c, z: (nx.d == 64'd0)});
    m16 = nx;
    s8.en  = 1'b0; s8.reset  = 1'b0;
    s16.en = 1'b0; s16.reset = 1'b0;
  endtask

  task automatic do8(input logic [2:0] op, input int unsigned k,
                     input logic [63:0] d, input logic s);
    s8 = '{reset: 1'b0, en: 1'b1, op: op, k: k, s: s, d: d};
    apply();
  endtask

  task automatic do16(input logic [2:0] op, input int unsigned k,
                      input logic [63:0] d, input logic s);
    s16 = '{reset: 1'b0, en: 1'b1, op: op, k: k, s: s, d: d};
    apply();
  endtask

  task automatic reset_both();
    s8  = '{reset: 1'b1, en: 1'b1, op: LOAD, k: 0, s: 1'b0, d: 64'hFF};
    s16 = '{reset: 1'b1, en: 1'b1, op: LOAD, k: 0, s: 1'b0, d: 64'hFFFF};
    apply();
  endtask

  initial begin
    logic [7:0] bits;
    int         g;
    s8  = '{reset: 1'b0, en: 1'b0, op: NOP, k: 0, s: 1'b0, d: 64'd0};
    s16 = s8;

    // Reset for two edges with LOAD 0xFF pending, then an LOAD with en low.
    reset_both();
    reset_both();
    s8 = '{reset: 1'b0, en: 1'b0, op: LOAD, k: 0, s: 1'b0, d: 64'h77};
    apply();

    // LOAD then LSL, including k = 0 hold.
    do8(LOAD, 0, 64'h77, 1'b0);
    do8(LSL, 1, 0, 1'b0);
    do8(LSL, 1, 0, 1'b0);
    do8(LSL, 0, 0, 1'b0);

    // LSR / ASR, including k > WIDTH and k == WIDTH.
    do8(LOAD, 0, 64'h88, 1'b0);
    do8(ASR, 2, 0, 1'b0);
    do8(ASR, 9, 0, 1'b0);
    do8(LOAD, 0, 64'h88, 1'b0);
    do8(LSR, 3, 0, 1'b0);
    do8(LSR, 8, 0, 1'b0);
    do8(LOAD, 0, 64'hC5, 1'b0);
    do8(LSL, 8, 0, 1'b0);
    do8(LOAD, 0, 64'hC5, 1'b0);
    do8(LSL, 12, 0, 1'b0);

    // Rotates; these act as NOP when the rotate feature is not built.
    do8(LOAD, 0, 64'h81, 1'b0);
    do8(ROL, 1, 0, 1'b0);
    do8(ROR, 2, 0, 1'b0);
    do8(ROL, 8, 0, 1'b0);
    do8(ROR, 11, 0, 1'b0);

    // Serial shift-in: 1,0,1,1,0,0,1,0, then a ninth SHIN.
    do8(LOAD, 0, 64'h00, 1'b0);
    bits = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) do8(SHIN, 5, 0, bits[i]);
    do8(SHIN, 0, 0, 1'b0);

    // Reset in the middle of an LSL stream, then a normal LOAD.
    do8(LOAD, 0, 64'h3C, 1'b0);
    do8(LSL, 1, 0, 1'b0);
    s8 = '{reset: 1'b1, en: 1'b1, op: LSL, k: 1, s: 1'b0, d: 64'd0};
    apply();
    do8(LOAD, 0, 64'h5A, 1'b0);

    // 16-bit instance: ASR/LSL/LSR boundaries.
    do16(LOAD, 0, 64'h8001, 1'b0);
    do16(ASR, 15, 0, 1'b0);
    do16(LOAD, 0, 64'h8001, 1'b0);
    do16(LSL, 1, 0, 1'b0);
    do16(LOAD, 0, 64'h8001, 1'b0);
    do16(LSR, 15, 0, 1'b0);
    do16(LOAD, 0, 64'hA5C3, 1'b0);
    do16(ROL, 4, 0, 1'b0);
    do16(ROR, 7, 0, 1'b0);

    // Randomised traffic on both instances at once.
    for (int n = 0; n < 600; n++) begin
      s8  = '{reset: ($urandom_range(0, 63) == 0), en: ($urandom_range(0, 7) != 0),
              op: 3'($urandom_range(0, 7)), k: $urandom_range(0, 15),
              s: 1'($urandom), d: {32'd0, $urandom}};
      s16 = '{reset: ($urandom_range(0, 63) == 0), en: ($urandom_range(0, 7) != 0),
              op: 3'($urandom_range(0, 7)), k: $urandom_range(0, 15),
              s: 1'($urandom), d: {32'd0, $urandom}};
      apply();
    end

    // Drain the scoreboard within a bounded number of cycles.
    g = 0;
    while ((q8.size() > 0 || q16.size() > 0) && g < 10) begin
      @(negedge clk);
      g++;
    end
    if (q8.size() > 0 || q16.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d/%0d expectations left, want 0/0", q8.size(), q16.size());
    end

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog in case the run stops making progress.
  initial begin
    #2_000_000;
    if (!done) begin
      $display("FAIL watchdog: run still active at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
    end
  end

endmodule

// File: doc/shifter_reg_n.md
Name: shifter_reg_n

Overview:
- Parametrised successor to the 8-bit op-coded shift register.
- Holds a WIDTH-bit register updated once per clock by a 3-bit op: load, logical/arithmetic shifts, rotates, serial shift-in.
- Adds an enable, a carry-out of the last bit shifted out, a zero flag, and defined behaviour for shift amounts ≥ WIDTH.
- Used as a datapath shift/rotate unit and as a serial-to-parallel shifter in the lab designs.

Parameters:
- WIDTH, 8, register/data width in bits; legal range 2..64.
- SHAMT_W, 3, width of shamt; legal range 1..7; shamt may exceed WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset; sampled on rising clk only.
- en  input  1  update enable; when 0 the register and flags hold.
- op  input  3  operation select, see Behaviour.
- shamt  input  SHAMT_W  shift/rotate amount k.
- s_in  input  1  serial input bit for op SHIN.
- d_in  input  WIDTH  parallel load data.
- d_out  output  WIDTH  registered shift register contents.
- carry  output  1  registered last bit shifted or rotated out.
- zero  output  1  combinational, 1 when d_out == 0.

Behaviour:
- Reset
  - Synchronous, active-high: one clock and one reset.
  - On a rising clk with reset=1: d_out=0, carry=0, so zero=1.
  - Reset overrides en and op.
  - Reset asserted in the middle of any op sequence clears state on that edge; the next edge with reset=0 resumes normal operation from d_out=0.
- Update rules
  - All updates occur on a rising clk with reset=0 and en=1; latency is 1 cycle from op/d_in/shamt to d_out.
  - en=0: d_out and carry hold, regardless of op.
  - Let D = current d_out and k = shamt, zero-extended.
- Op encodings
  - 000 NOP: hold D and carry.
  - 001 LOAD: d_out=d_in, carry=0.
  - 010 LSL: d_out=D<<k, zero fill.
  - 011 LSR: d_out=D>>k, zero fill.
  - 100 ASR: d_out=D>>k, fill with D[WIDTH-1].
  - 101 ROL: d_out=D rotated left by k mod WIDTH.
  - 110 ROR: d_out=D rotated right by k mod WIDTH.
  - 111 SHIN: d_out={D[WIDTH-2:0], s_in}; ignores shamt.
- carry rules
  - k=0, any shift/rotate: d_out and carry unchanged.
  - LSL, 1≤k≤WIDTH: carry=D[WIDTH-k].
  - LSR/ASR, 1≤k≤WIDTH: carry=D[k-1].
  - k>WIDTH: LSL/LSR carry=0; ASR carry=D[WIDTH-1].
  - k≥WIDTH: LSL/LSR give d_out=0; ASR gives d_out = all copies of D[WIDTH-1].
  - ROL (k mod WIDTH ≠ 0): carry = new d_out[0].
  - ROR (k mod WIDTH ≠ 0): carry = new d_out[WIDTH-1].
  - ROL/ROR with k mod WIDTH = 0: no change, carry holds.
  - SHIN: carry=D[WIDTH-1].
- Flags and inputs
  - zero is derived from the registered d_out only; no extra latency.
  - No X propagation: all op codes are defined, and unused shamt bits are legal.

Optional Feature:
- Macro SHIFTER_ROTATE_EN.
- Defined: ROL/ROR implemented as above.
- Undefined: ops 101 and 110 behave exactly as NOP (d_out and carry hold), and rotate logic is not synthesised. All other ops are identical in both builds.

Test Plan:
- Reset and hold:
  - reset=1 for 2 edges with op=LOAD, d_in=0xFF → d_out=0x00, carry=0, zero=1.
  - reset=0, en=0, op=LOAD d_in=0x77 → d_out stays 0x00.
- LOAD then LSL (WIDTH=8):
  - LOAD 0x77 → 0x77, carry=0, zero=0.
  - LSL k=1 → 0xEE, carry=0.
  - LSL k=1 → 0xDC, carry=1.
  - LSL k=0 → 0xDC, carry=1 (held).
- LSR/ASR:
  - LOAD 0x88, ASR k=2 → 0xE2, carry=0.
  - ASR k=9 → 0xFF, carry=1.
  - LOAD 0x88, LSR k=3 → 0x11, carry=0.
  - LSR k=8 → 0x00, carry=0, zero=1.
- Rotates (macro defined):
  - LOAD 0x81, ROL k=1 → 0x03, carry=1.
  - ROR k=2 → 0xC0, carry=1.
  - ROL k=8 → 0xC0 unchanged.
  - Macro undefined: ROL k=1 on 0x81 → 0x81, carry=0.
- Serial shift-in:
  - From 0x00, eight SHIN cycles with s_in=1,0,1,1,0,0,1,0 → d_out=0xB2.
  - carry on the 9th SHIN equals bit7 of 0xB2 = 1.
- Reset mid-sequence and parametrised width:
  - Assert reset during an LSL stream → d_out=0 on that edge; the following LOAD 0x5A works normally.
  - Repeat the LSL/ASR cases with WIDTH=16, SHAMT_W=4: LOAD 0x8001, ASR k=15 → 0xFFFF, carry=0.
